writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 144 ++++++++++++++
 tb/tb_writeback_stage.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU, link and load results into the register file.
// Loads wait for a data-memory response and then get lane extraction and alignment checks.
module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_write,
    input  logic [4:0]  in_rd_addr,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc_plus4,
    input  logic [2:0]  in_funct3,
    input  logic        flush,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_rd_addr,
    output logic [31:0] rf_rd_data,
    output logic        load_fault,
    output logic [31:0] retire_count
);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic        rf_we_reg;
    logic [4:0]  rf_rd_addr_reg;
    logic [31:0] rf_rd_data_reg;
    logic        load_fault_reg;
    logic [31:0] retire_count_reg;

    logic        ld_we_reg;
    logic [4:0]  ld_rd_reg;
    logic [2:0]  ld_funct3_reg;
    logic [1:0]  ld_off_reg;

    logic        accept;
    logic        is_load;
    logic        load_done;
    logic        ld_fault;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign in_ready     = (state_reg == IDLE);
    assign accept       = in_valid && in_ready && !flush;
    assign is_load      = (in_wb_sel == 2'b01);
    assign load_done    = (state_reg == WAIT_LOAD) && dmem_rvalid && !flush;

    assign rf_we        = rf_we_reg;
    assign rf_rd_addr   = rf_rd_addr_reg;
    assign rf_rd_data   = rf_rd_data_reg;
    assign load_fault   = load_fault_reg;
    assign retire_count = retire_count_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (accept && is_load) state_next = WAIT_LOAD;
            WAIT_LOAD: begin
                // A flush racing the response drops it and needs no drain.
                if (flush)
                    state_next = dmem_rvalid ? IDLE : DRAIN;
                else if (dmem_rvalid)
                    state_next = IDLE;
            end
            DRAIN:     if (dmem_rvalid) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        ld_byte  = dmem_rdata[8*ld_off_reg +: 8];
        ld_half  = ld_off_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_value = 32'd0;
        ld_fault = 1'b0;
        case (ld_funct3_reg)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b001: begin
                ld_value = {{16{ld_half[15]}}, ld_half};
                ld_fault = ld_off_reg[0];
            end
            3'b101: begin
                ld_value = {16'd0, ld_half};
                ld_fault = ld_off_reg[0];
            end
            3'b010: begin
                ld_value = dmem_rdata;
                ld_fault = (ld_off_reg != 2'b00);
            end
            default: ld_fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            rf_we_reg        <= 1'b0;
            rf_rd_addr_reg   <= 5'd0;
            rf_rd_data_reg   <= 32'd0;
            load_fault_reg   <= 1'b0;
            retire_count_reg <= 32'd0;
            ld_we_reg        <= 1'b0;
            ld_rd_reg        <= 5'd0;
            ld_funct3_reg    <= 3'd0;
            ld_off_reg       <= 2'd0;
        end else begin
            state_reg      <= state_next;
            rf_we_reg      <= 1'b0;
            load_fault_reg <= 1'b0;
            if (accept) begin
                if (is_load) begin
                    ld_we_reg     <= in_reg_write;
                    ld_rd_reg     <= in_rd_addr;
                    ld_funct3_reg <= in_funct3;
                    ld_off_reg    <= in_alu_result[1:0];
                end else begin
                    // Writes to x0 or non-writing ops still retire; outputs hold otherwise.
                    if (in_reg_write && in_rd_addr != 5'd0) begin
                        rf_we_reg      <= 1'b1;
                        rf_rd_addr_reg <= in_rd_addr;
                        rf_rd_data_reg <= (in_wb_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
                    end
                    retire_count_reg <= retire_count_reg + 32'd1;
                end
            end
            if (load_done) begin
                if (ld_fault) begin
                    load_fault_reg <= 1'b1;
                end else begin
                    if (ld_we_reg && ld_rd_reg != 5'd0) begin
                        rf_we_reg      <= 1'b1;
                        rf_rd_addr_reg <= ld_rd_reg;
                        rf_rd_data_reg <= ld_value;
                    end
                    retire_count_reg <= retire_count_reg + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases plus randomized ALU/load traffic
// compared against an arithmetic reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_rd_addr = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc_plus4 = '0;
    logic [2:0]  in_funct3 = '0;
    logic        flush = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        load_fault;
    logic [31:0] retire_count;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_retire = '0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    writeback_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_rd_addr(in_rd_addr), .in_wb_sel(in_wb_sel),
        .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_funct3(in_funct3),
        .flush(flush), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .load_fault(load_fault), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Reference model: architectural result of a load from the word at addr.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        logic [31:0] s;
        s = word >> ((addr % 4) * 8);
        case (f3)
            3'd0:    return 32'($signed(s[7:0]));
            3'd4:    return s & 32'h0000_00FF;
            3'd1:    return 32'($signed(s[15:0]));
            3'd5:    return s & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] addr);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) return 1'b1;
        if (f3 == 3'd2 && (addr % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
        in_valid      = 1'b1;
        in_reg_write  = we;
        in_rd_addr    = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc_plus4   = pc4;
        in_funct3     = f3;
    endtask

    // Issues a load, waits `delay` idle cycles, delivers the response; returns with the
    // result cycle visible. busy_ok reports whether in_ready stayed low throughout the wait.
    task automatic run_load(input logic we, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] word, input int delay,
                            output bit busy_ok);
        set_op(we, rd, 2'b01, addr, 32'd0, f3);
        tick();
        in_valid = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < delay; i++) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
        end
        if (in_ready !== 1'b0) busy_ok = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = word;
        tick();
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || load_fault !== 1'b0 || rf_rd_addr !== 5'd0 ||
            rf_rd_data !== 32'd0 || retire_count !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: we=%b fault=%b addr=%0d data=%h retire=%0d ready=%b, required all zero and ready=1",
                     rf_we, load_fault, rf_rd_addr, rf_rd_data, retire_count, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_alu();
        logic        we;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] alu, pc4, val;
        set_op(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'd0);
        tick();
        in_valid = 1'b0;
        exp_retire++; exp_addr = 5'd5; exp_data = 32'h1234_5678;
        checks++;
        if (rf_we !== 1'b1 || rf_rd_addr !== 5'd5 || rf_rd_data !== 32'h1234_5678 || retire_count !== 32'd1) begin
            failures++;
            $display("FAIL alu_directed: we=%b addr=%0d data=%h retire=%0d, required we=1 addr=5 data=12345678 retire=1",
                     rf_we, rf_rd_addr, rf_rd_data, retire_count);
        end
        tick();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL alu_pulse: rf_we=%b, required 0", rf_we);
        end
        for (int n = 0; n < 12; n++) begin
            we  = 1'($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 31));
            sel = 2'($urandom_range(0, 3));
            if (sel == 2'b01) sel = 2'b11;
            alu = $urandom; pc4 = $urandom;
            set_op(we, rd, sel, alu, pc4, 3'($urandom_range(0, 7)));
            tick();
            in_valid = 1'b0;
            val = (sel == 2'b10) ? pc4 : alu;
            exp_retire++;
            if (we && rd != 0) begin exp_addr = rd; exp_data = val; end
            checks++;
            if (rf_we !== (we && rd != 0) || rf_rd_addr !== exp_addr || rf_rd_data !== exp_data ||
                retire_count !== exp_retire || load_fault !== 1'b0) begin
                failures++;
                $display("FAIL alu_random[%0d]: we=%b addr=%0d data=%h retire=%0d fault=%b, required we=%b addr=%0d data=%h retire=%0d fault=0",
                         n, rf_we, rf_rd_addr, rf_rd_data, retire_count, load_fault,
                         (we && rd != 0), exp_addr, exp_data, exp_retire);
            end
        end
        $display("test_alu done");
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rd;
        logic [31:0] alu;
        for (int n = 0; n < 8; n++) begin
            rd  = 5'($urandom_range(1, 31));
            alu = $urandom;
            set_op(1'b1, rd, 2'b00, alu, 32'h0, 3'd0);
            tick();
            exp_retire++; exp_addr = rd; exp_data = alu;
            checks++;
            if (rf_we !== 1'b1 || rf_rd_addr !== exp_addr || rf_rd_data !== exp_data || retire_count !== exp_retire) begin
                failures++;
                $display("FAIL back_to_back[%0d]: we=%b addr=%0d data=%h retire=%0d, required we=1 addr=%0d data=%h retire=%0d",
                         n, rf_we, rf_rd_addr, rf_rd_data, retire_count, exp_addr, exp_data, exp_retire);
            end
        end
        in_valid = 1'b0;
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_load();
        bit          busy_ok, f;
        logic [2:0]  f3;
        logic [31:0] addr, word, val;
        logic [4:0]  rd;
        logic        we;
        run_load(1'b1, 5'd7, 3'd0, 32'h1003, 32'h80FF_FFFF, 3, busy_ok);
        exp_retire++; exp_addr = 5'd7; exp_data = 32'hFFFF_FF80;
        checks++;
        if (!busy_ok || rf_we !== 1'b1 || rf_rd_data !== 32'hFFFF_FF80 || rf_rd_addr !== 5'd7 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL lb_directed: busy_ok=%b we=%b addr=%0d data=%h retire=%0d, required busy_ok=1 we=1 addr=7 data=ffffff80 retire=%0d",
                     busy_ok, rf_we, rf_rd_addr, rf_rd_data, retire_count, exp_retire);
        end
        run_load(1'b1, 5'd8, 3'd4, 32'h1003, 32'h80FF_FFFF, 3, busy_ok);
        exp_retire++; exp_addr = 5'd8; exp_data = 32'h0000_0080;
        checks++;
        if (!busy_ok || rf_we !== 1'b1 || rf_rd_data !== 32'h0000_0080 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL lbu_directed: busy_ok=%b we=%b data=%h retire=%0d, required busy_ok=1 we=1 data=00000080 retire=%0d",
                     busy_ok, rf_we, rf_rd_data, retire_count, exp_retire);
        end
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 5))
                0: f3 = 3'd0; 1: f3 = 3'd4; 2: f3 = 3'd1; 3: f3 = 3'd5; 4: f3 = 3'd2;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            addr = $urandom;
            if ($urandom_range(0, 1) == 1 && (f3 == 3'd1 || f3 == 3'd5)) addr[0] = 1'b0;
            if ($urandom_range(0, 1) == 1 && f3 == 3'd2) addr[1:0] = 2'b00;
            word = $urandom;
            rd   = 5'($urandom_range(0, 31));
            we   = 1'($urandom_range(0, 3) != 0);
            run_load(we, rd, f3, addr, word, $urandom_range(0, 3), busy_ok);
            f = model_fault(f3, addr);
            if (!f) begin
                exp_retire++;
                if (we && rd != 0) begin exp_addr = rd; exp_data = model_load(f3, addr, word); end
            end
            val = exp_data;
            checks++;
            if (!busy_ok || load_fault !== f || rf_we !== (!f && we && rd != 0) ||
                rf_rd_addr !== exp_addr || rf_rd_data !== val || retire_count !== exp_retire) begin
                failures++;
                $display("FAIL load_random[%0d] f3=%0d addr=%h word=%h: busy_ok=%b fault=%b we=%b addr=%0d data=%h retire=%0d, required fault=%b we=%b addr=%0d data=%h retire=%0d",
                         n, f3, addr, word, busy_ok, load_fault, rf_we, rf_rd_addr, rf_rd_data, retire_count,
                         f, (!f && we && rd != 0), exp_addr, val, exp_retire);
            end
        end
        $display("test_load done");
    endtask

    task automatic test_fault();
        bit busy_ok;
        run_load(1'b1, 5'd9, 3'd1, 32'h1001, 32'hDEAD_BEEF, 1, busy_ok);
        checks++;
        if (load_fault !== 1'b1 || rf_we !== 1'b0 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL lh_misaligned: fault=%b we=%b retire=%0d, required fault=1 we=0 retire=%0d",
                     load_fault, rf_we, retire_count, exp_retire);
        end
        tick();
        checks++;
        if (load_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_pulse: load_fault=%b, required 0", load_fault);
        end
        run_load(1'b1, 5'd9, 3'd2, 32'h1002, 32'hDEAD_BEEF, 0, busy_ok);
        checks++;
        if (load_fault !== 1'b1 || rf_we !== 1'b0 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL lw_misaligned: fault=%b we=%b retire=%0d, required fault=1 we=0 retire=%0d",
                     load_fault, rf_we, retire_count, exp_retire);
        end
        run_load(1'b1, 5'd9, 3'd6, 32'h1000, 32'hDEAD_BEEF, 2, busy_ok);
        checks++;
        if (load_fault !== 1'b1 || rf_we !== 1'b0 || retire_count !== exp_retire || rf_rd_data !== exp_data) begin
            failures++;
            $display("FAIL illegal_funct3: fault=%b we=%b retire=%0d data=%h, required fault=1 we=0 retire=%0d data=%h",
                     load_fault, rf_we, retire_count, rf_rd_data, exp_retire, exp_data);
        end
        $display("test_fault done");
    endtask

    task automatic test_flush();
        // Flush one cycle after accepting a load, response arrives while draining.
        set_op(1'b1, 5'd10, 2'b01, 32'h2000, 32'h0, 3'd2);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL flush_drain_busy: ready=%b we=%b, required ready=0 we=0", in_ready, rf_we);
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || rf_we !== 1'b0 || load_fault !== 1'b0 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL flush_drain_done: ready=%b we=%b fault=%b retire=%0d, required ready=1 we=0 fault=0 retire=%0d",
                     in_ready, rf_we, load_fault, retire_count, exp_retire);
        end
        set_op(1'b1, 5'd11, 2'b00, 32'h0BAD_CAFE, 32'h0, 3'd0);
        tick();
        in_valid = 1'b0;
        exp_retire++; exp_addr = 5'd11; exp_data = 32'h0BAD_CAFE;
        checks++;
        if (rf_we !== 1'b1 || rf_rd_addr !== 5'd11 || rf_rd_data !== 32'h0BAD_CAFE || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL alu_after_flush: we=%b addr=%0d data=%h retire=%0d, required we=1 addr=11 data=0badcafe retire=%0d",
                     rf_we, rf_rd_addr, rf_rd_data, retire_count, exp_retire);
        end
        // Flush and response in the same cycle go straight back to IDLE.
        set_op(1'b1, 5'd12, 2'b01, 32'h3000, 32'h0, 3'd2);
        tick();
        in_valid = 1'b0;
        flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        tick();
        flush = 1'b0; dmem_rvalid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || rf_we !== 1'b0 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL flush_with_rvalid: ready=%b we=%b retire=%0d, required ready=1 we=0 retire=%0d",
                     in_ready, rf_we, retire_count, exp_retire);
        end
        // Flush in IDLE blocks the transfer but a registered write still shows.
        set_op(1'b1, 5'd13, 2'b00, 32'h5555_AAAA, 32'h0, 3'd0);
        tick();
        exp_retire++; exp_addr = 5'd13; exp_data = 32'h5555_AAAA;
        flush = 1'b1;
        set_op(1'b1, 5'd14, 2'b00, 32'h7777_7777, 32'h0, 3'd0);
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_rd_data !== 32'h5555_AAAA) begin
            failures++;
            $display("FAIL flush_pending_write: we=%b data=%h, required we=1 data=5555aaaa", rf_we, rf_rd_data);
        end
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || retire_count !== exp_retire || rf_rd_data !== exp_data) begin
            failures++;
            $display("FAIL flush_idle_blocks: we=%b retire=%0d data=%h, required we=0 retire=%0d data=%h",
                     rf_we, retire_count, rf_rd_data, exp_retire, exp_data);
        end
        // A response arriving in IDLE is ignored.
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || load_fault !== 1'b0 || retire_count !== exp_retire || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_rvalid: we=%b fault=%b retire=%0d ready=%b, required we=0 fault=0 retire=%0d ready=1",
                     rf_we, load_fault, retire_count, in_ready, exp_retire);
        end
        $display("test_flush done");
    endtask

    task automatic test_jal_wrap();
        set_op(1'b1, 5'd0, 2'b10, 32'h0, 32'h0000_0104, 3'd0);
        tick();
        in_valid = 1'b0;
        exp_retire++;
        checks++;
        if (rf_we !== 1'b0 || retire_count !== exp_retire || rf_rd_data !== exp_data) begin
            failures++;
            $display("FAIL jal_rd0: we=%b retire=%0d data=%h, required we=0 retire=%0d data=%h",
                     rf_we, retire_count, rf_rd_data, exp_retire, exp_data);
        end
        set_op(1'b1, 5'd1, 2'b10, 32'h0, 32'h0000_0204, 3'd0);
        tick();
        in_valid = 1'b0;
        exp_retire++; exp_addr = 5'd1; exp_data = 32'h0000_0204;
        checks++;
        if (rf_we !== 1'b1 || rf_rd_addr !== 5'd1 || rf_rd_data !== 32'h0000_0204 || retire_count !== exp_retire) begin
            failures++;
            $display("FAIL jal_link: we=%b addr=%0d data=%h retire=%0d, required we=1 addr=1 data=00000204 retire=%0d",
                     rf_we, rf_rd_addr, rf_rd_data, retire_count, exp_retire);
        end
        dut.retire_count_reg = 32'hFFFF_FFFF;
        set_op(1'b1, 5'd0, 2'b10, 32'h0, 32'h0000_0108, 3'd0);
        tick();
        in_valid = 1'b0;
        exp_retire = 32'd0;
        checks++;
        if (retire_count !== 32'd0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL retire_wrap: retire=%h we=%b, required retire=00000000 we=0", retire_count, rf_we);
        end
        $display("test_jal_wrap done");
    endtask

    task automatic test_reset_midload();
        set_op(1'b1, 5'd15, 2'b01, 32'h4000, 32'h0, 3'd2);
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rf_we !== 1'b0 || load_fault !== 1'b0 || rf_rd_addr !== 5'd0 || rf_rd_data !== 32'd0 ||
            retire_count !== 32'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_midload: we=%b fault=%b addr=%0d data=%h retire=%0d ready=%b, required zeros and ready=1",
                     rf_we, load_fault, rf_rd_addr, rf_rd_data, retire_count, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_retire = '0; exp_addr = '0; exp_data = '0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h9999_9999;
        tick();
        dmem_rvalid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || load_fault !== 1'b0 || retire_count !== 32'd0 || rf_rd_data !== 32'd0) begin
            failures++;
            $display("FAIL rvalid_after_reset: we=%b fault=%b retire=%0d data=%h, required we=0 fault=0 retire=0 data=0",
                     rf_we, load_fault, retire_count, rf_rd_data);
        end
        $display("test_reset_midload done");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_fault();
        test_flush();
        test_jal_wrap();
        test_reset_midload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
